// File: rtl/pll_rst_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and counter sizing.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SOFT      = 3'd4
    } state_t;

    // Width able to hold max(a, b, c) - 1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by async active-low reset.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Two-stage reset release after PLL lock qualification, with core-only soft reset.
// Optional lock-loss event counter enabled by defining PLL_LOCK_LOSS_CNT_EN.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 4096,
    parameter int unsigned STAGE_GAP          = 16,
    parameter int unsigned SOFT_RST_CYCLES    = 64,
    parameter int unsigned CNT_W              = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             soft_rst_req,
    output logic             sys_rst_n,
    output logic             core_rst_n,
`ifdef PLL_LOCK_LOSS_CNT_EN
    output logic [CNT_W-1:0] lock_loss_count,
`endif
    output logic             ready
);

    localparam int unsigned CW = cnt_width(LOCK_STABLE_CYCLES, STAGE_GAP, SOFT_RST_CYCLES);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] SOFT_LAST   = CW'(SOFT_RST_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic          w_lock_s;
    state_t        r_state;
    state_t        w_state_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
    logic          r_sys;
    logic          r_core;
    logic          r_ready;
    logic          w_sys_d;
    logic          w_core_d;
    logic          w_ready_d;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_d       (pll_locked),
        .o_q       (w_lock_s)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
            r_sys   <= 1'b0;
            r_core  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_sys   <= w_sys_d;
            r_core  <= w_core_d;
            r_ready <= w_ready_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        // Lock loss overrides every other transition, including a same-edge soft request.
        if ((r_state != WAIT_LOCK) && !w_lock_s) begin
            w_state_d = WAIT_LOCK;
        end else begin
            unique case (r_state)
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_d = STABLE;
                        w_cnt_d   = '0;
                    end
                end
                STABLE: begin
                    if (r_cnt == STABLE_LAST) begin
                        w_state_d = RELEASE;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (r_cnt == GAP_LAST) begin
                        w_state_d = RUN;
                    end else begin
                        w_cnt_d = r_cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (soft_rst_req) begin
                        w_state_d = SOFT;
                        w_cnt_d   = '0;
                    end
                end
                SOFT: begin
                    if (r_cnt == SOFT_LAST) begin
                        w_state_d = RUN;
                    end else begin
                        w_cnt_d = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_d = WAIT_LOCK;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        w_sys_d   = (w_state_d == RELEASE) || (w_state_d == RUN) || (w_state_d == SOFT);
        w_core_d  = (w_state_d == RUN);
        w_ready_d = (w_state_d == RUN);
    end

    assign sys_rst_n  = r_sys;
    assign core_rst_n = r_core;
    assign ready      = r_ready;

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic             w_loss;
    logic [CNT_W-1:0] r_loss_cnt;

    assign w_loss = (r_state != WAIT_LOCK) && !w_lock_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss && (r_loss_cnt != {CNT_W{1'b1}})) begin
            r_loss_cnt <= r_loss_cnt + CNT_W'(1);
        end
    end

    assign lock_loss_count = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer (small timing parameters).
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int unsigned CNT_W = 4;

    logic clock = 1'b0;
    logic reset_n;
    logic pll_locked;
    logic soft_rst_req;
    logic sys_rst_n;
    logic core_rst_n;
    logic ready;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [CNT_W-1:0] lock_loss_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .STAGE_GAP          (4),
        .SOFT_RST_CYCLES    (6),
        .CNT_W              (CNT_W)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .soft_rst_req    (soft_rst_req),
        .sys_rst_n       (sys_rst_n),
        .core_rst_n      (core_rst_n),
`ifdef PLL_LOCK_LOSS_CNT_EN
        .lock_loss_count (lock_loss_count),
`endif
        .ready           (ready)
    );

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        pll_locked   = 1'b1;
        soft_rst_req = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({sys_rst_n, core_rst_n, ready} !== 3'b000) begin
            $display("FAIL reset_outputs: got %b expected 000", {sys_rst_n, core_rst_n, ready});
            n_errors++;
        end
`ifdef PLL_LOCK_LOSS_CNT_EN
        n_checks++;
        if (lock_loss_count !== 4'd0) begin
            $display("FAIL reset_count: got %0d expected 0", lock_loss_count);
            n_errors++;
        end
`endif
        reset_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            n_checks++;
            if (sys_rst_n !== (e >= 11)) begin
                $display("FAIL powerup_sys edge %0d: got %b expected %b", e, sys_rst_n, e >= 11);
                n_errors++;
            end
            n_checks++;
            if ({core_rst_n, ready} !== {2{e >= 15}}) begin
                $display("FAIL powerup_core_ready edge %0d: got %b expected %b", e,
                         {core_rst_n, ready}, {2{e >= 15}});
                n_errors++;
            end
        end
    endtask

    task automatic test_lock_loss();
        pll_locked = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_checks++;
            if ({sys_rst_n, core_rst_n, ready} !== {3{e < 3}}) begin
                $display("FAIL lockloss_outputs edge %0d: got %b expected %b", e,
                         {sys_rst_n, core_rst_n, ready}, {3{e < 3}});
                n_errors++;
            end
        end
`ifdef PLL_LOCK_LOSS_CNT_EN
        n_checks++;
        if (lock_loss_count !== 4'd1) begin
            $display("FAIL lockloss_count: got %0d expected 1", lock_loss_count);
            n_errors++;
        end
`endif
        pll_locked = 1'b1;
        repeat (15) tick();
        n_checks++;
        if (ready !== 1'b1) begin
            $display("FAIL lockloss_relock_ready: got %b expected 1", ready);
            n_errors++;
        end
    endtask

    task automatic test_glitch();
        pll_locked = 1'b0;
        repeat (4) tick();
        pll_locked = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) pll_locked = 1'b0;
            tick();
            n_checks++;
            if (sys_rst_n !== 1'b0) begin
                $display("FAIL glitch_hold cycle %0d: got %b expected 0", c, sys_rst_n);
                n_errors++;
            end
        end
        pll_locked = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            n_checks++;
            if (sys_rst_n !== (e >= 11)) begin
                $display("FAIL glitch_sys edge %0d: got %b expected %b", e, sys_rst_n, e >= 11);
                n_errors++;
            end
            if (e >= 14) begin
                n_checks++;
                if (ready !== (e >= 15)) begin
                    $display("FAIL glitch_ready edge %0d: got %b expected %b", e, ready, e >= 15);
                    n_errors++;
                end
            end
        end
`ifdef PLL_LOCK_LOSS_CNT_EN
        n_checks++;
        if (lock_loss_count !== 4'd3) begin
            $display("FAIL glitch_count: got %0d expected 3", lock_loss_count);
            n_errors++;
        end
`endif
    endtask

    task automatic test_soft_reset();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        n_checks++;
        if ({sys_rst_n, core_rst_n, ready} !== 3'b100) begin
            $display("FAIL soft_enter: got %b expected 100", {sys_rst_n, core_rst_n, ready});
            n_errors++;
        end
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) soft_rst_req = 1'b1;
            tick();
            soft_rst_req = 1'b0;
            n_checks++;
            if ({sys_rst_n, core_rst_n, ready} !== {1'b1, {2{k >= 6}}}) begin
                $display("FAIL soft_hold k=%0d: got %b expected %b", k,
                         {sys_rst_n, core_rst_n, ready}, {1'b1, {2{k >= 6}}});
                n_errors++;
            end
        end
        // Soft request on the same edge lock loss takes effect.
        pll_locked = 1'b0;
        repeat (2) tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        n_checks++;
        if ({sys_rst_n, core_rst_n, ready} !== 3'b000) begin
            $display("FAIL soft_vs_loss: got %b expected 000", {sys_rst_n, core_rst_n, ready});
            n_errors++;
        end
        tick();
        n_checks++;
        if (sys_rst_n !== 1'b0) begin
            $display("FAIL soft_vs_loss_after: got %b expected 0", sys_rst_n);
            n_errors++;
        end
        // Soft request during STABLE is ignored.
        pll_locked = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            if (e == 6) soft_rst_req = 1'b1;
            tick();
            soft_rst_req = 1'b0;
            n_checks++;
            if ({sys_rst_n, core_rst_n} !== {e >= 11, e >= 15}) begin
                $display("FAIL soft_in_stable edge %0d: got %b expected %b", e,
                         {sys_rst_n, core_rst_n}, {e >= 11, e >= 15});
                n_errors++;
            end
        end
`ifdef PLL_LOCK_LOSS_CNT_EN
        n_checks++;
        if (lock_loss_count !== 4'd4) begin
            $display("FAIL soft_count: got %0d expected 4", lock_loss_count);
            n_errors++;
        end
`endif
    endtask

    task automatic test_async_reset();
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({sys_rst_n, core_rst_n, ready} !== 3'b000) begin
            $display("FAIL async_run: got %b expected 000", {sys_rst_n, core_rst_n, ready});
            n_errors++;
        end
`ifdef PLL_LOCK_LOSS_CNT_EN
        n_checks++;
        if (lock_loss_count !== 4'd0) begin
            $display("FAIL async_count: got %0d expected 0", lock_loss_count);
            n_errors++;
        end
`endif
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({sys_rst_n, core_rst_n, ready} !== 3'b000) begin
            $display("FAIL async_stable: got %b expected 000", {sys_rst_n, core_rst_n, ready});
            n_errors++;
        end
        tick();
        reset_n = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            n_checks++;
            if (sys_rst_n !== (e >= 11)) begin
                $display("FAIL async_requal edge %0d: got %b expected %b", e, sys_rst_n, e >= 11);
                n_errors++;
            end
        end
    endtask

`ifdef PLL_LOCK_LOSS_CNT_EN
    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            pll_locked = 1'b0;
            repeat (4) tick();
            n_checks++;
            if (lock_loss_count !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
                $display("FAIL sat_count loss %0d: got %0d expected %0d", i + 1, lock_loss_count,
                         (i + 1 > 15) ? 15 : i + 1);
                n_errors++;
            end
            pll_locked = 1'b1;
            repeat (4) tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock_loss();
        test_glitch();
        test_soft_reset();
        test_async_reset();
`ifdef PLL_LOCK_LOSS_CNT_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
